// File: rtl/lsu_mem_if.sv
// lsu_mem_if: load/store initiator for a word-indexed data memory.
// Accepts one load or store at a time, issues word read/write requests over a
// req/ack handshake, performs read-modify-write for SB/SH and lane extraction
// with sign/zero extension for LB/LH/LBU/LHU. Reports misaligned, illegal and
// timeout faults.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   start, is_load, is_store  command strobe and kind (sampled only in IDLE)
//   funct3, addr, wdata       RISC-V width/sign field, byte address, store data
//   busy, done                not-IDLE flag, one-cycle completion pulse
//   rdata, fault              extended load result, 0 ok/1 misaligned/2 illegal/3 timeout
//   mem_req, mem_we           memory request and write enable
//   mem_addr, mem_wdata       word index and full write word
//   mem_rdata, mem_ack        read word and request-complete handshake
module lsu_mem_if #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic [1:0]  fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, FIN = 2'd3} state_t;

    // Counter value on the last request cycle before an access is aborted.
    localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);

    state_t      state_r;
    logic        load_r;
    logic [2:0]  f3_r;
    logic [1:0]  lane_r;
    logic [31:0] wdata_r;
    logic [7:0]  tcnt_r;
    logic [1:0]  dec_fault_s;
    logic        timeout_s;

    // Extract the addressed byte/half from a memory word and extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  lane);
        logic [31:0] shifted;
        logic [15:0] half;
        logic [31:0] res;
        shifted = word >> {lane, 3'b000};
        half    = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'd0:    res = {{24{shifted[7]}}, shifted[7:0]};
            3'd4:    res = {24'h000000, shifted[7:0]};
            3'd1:    res = {{16{half[15]}}, half};
            3'd5:    res = {16'h0000, half};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the selected lane(s) of the old memory word with store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] data,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane);
        logic [31:0] res;
        res = word;
        case (f3)
            3'd0: begin
                case (lane)
                    2'd0:    res[7:0]   = data[7:0];
                    2'd1:    res[15:8]  = data[7:0];
                    2'd2:    res[23:16] = data[7:0];
                    2'd3:    res[31:24] = data[7:0];
                    default: res        = word;
                endcase
            end
            3'd1: begin
                if (lane[1]) begin
                    res[31:16] = data[15:0];
                end else begin
                    res[15:0] = data[15:0];
                end
            end
            default: res = data;
        endcase
        return res;
    endfunction

    // Classify the incoming command: 0 = legal, 1 = misaligned, 2 = illegal.
    always_comb begin
        dec_fault_s = 2'd0;
        if (is_load && is_store) begin
            dec_fault_s = 2'd2;
        end else if (is_load || is_store) begin
            case (funct3)
                3'd0:    dec_fault_s = 2'd0;
                3'd1:    dec_fault_s = addr[0] ? 2'd1 : 2'd0;
                3'd2:    dec_fault_s = (addr[1:0] != 2'b00) ? 2'd1 : 2'd0;
                3'd4:    dec_fault_s = is_load ? 2'd0 : 2'd2;
                3'd5:    dec_fault_s = is_load ? (addr[0] ? 2'd1 : 2'd0) : 2'd2;
                default: dec_fault_s = 2'd2;
            endcase
        end else begin
            dec_fault_s = 2'd0;
        end
    end

    assign timeout_s = (tcnt_r == TLIM);

    // Command FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rdata     <= 32'h0000_0000;
            fault     <= 2'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0000_0000;
            mem_wdata <= 32'h0000_0000;
            load_r    <= 1'b0;
            f3_r      <= 3'd0;
            lane_r    <= 2'd0;
            wdata_r   <= 32'h0000_0000;
            tcnt_r    <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start && (is_load || is_store)) begin
                        busy    <= 1'b1;
                        load_r  <= is_load;
                        f3_r    <= funct3;
                        lane_r  <= addr[1:0];
                        wdata_r <= wdata;
                        tcnt_r  <= 8'd0;
                        fault   <= dec_fault_s;
                        if (dec_fault_s != 2'd0) begin
                            state_r <= FIN;
                            done    <= 1'b1;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= {2'b00, addr[31:2]};
                            // Full-word stores need no read phase.
                            if (is_store && (funct3 == 3'd2)) begin
                                state_r   <= WR;
                                mem_we    <= 1'b1;
                                mem_wdata <= wdata;
                            end else begin
                                state_r <= RD;
                                mem_we  <= 1'b0;
                            end
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                RD: begin
                    if (mem_ack) begin
                        tcnt_r <= 8'd0;
                        if (load_r) begin
                            rdata   <= load_extract(mem_rdata, f3_r, lane_r);
                            mem_req <= 1'b0;
                            state_r <= FIN;
                            done    <= 1'b1;
                        end else begin
                            // Request stays high: read phase flows straight into write.
                            mem_wdata <= store_merge(mem_rdata, wdata_r, f3_r, lane_r);
                            mem_we    <= 1'b1;
                            state_r   <= WR;
                        end
                    end else if (timeout_s) begin
                        mem_req <= 1'b0;
                        fault   <= 2'd3;
                        state_r <= FIN;
                        done    <= 1'b1;
                    end else begin
                        tcnt_r <= tcnt_r + 8'd1;
                    end
                end
                WR: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state_r <= FIN;
                        done    <= 1'b1;
                    end else if (timeout_s) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        fault   <= 2'd3;
                        state_r <= FIN;
                        done    <= 1'b1;
                    end else begin
                        tcnt_r <= tcnt_r + 8'd1;
                    end
                end
                FIN: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule
